// File: rtl/billiard_match_ctrl.sv
`default_nettype none
// ============================================================================
// billiard_match_ctrl : shot sequencer, pocket target, score and attempts for the table.
// Optional: BILLIARD_STREAK_BONUS_EN doubles the sink value while a clean-shot streak is live.
// Rev 1.0
// ============================================================================
module billiard_match_ctrl #(
   parameter int NUM_BALLS     = 3,
   parameter int NUM_HOLES     = 6,
   parameter int ATTEMPTS      = 10,
   parameter int HIT_SCORE     = 16,
   parameter int FOUL_SCORE    = 8,
   parameter int SCORE_W       = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                                          clk,
   input  logic                                          resetN,
   input  logic                                          enterPressed,
   input  logic [NUM_BALLS:0]                            ballStopped,
   input  logic [NUM_BALLS:0]                            ballHoleHit,
   input  logic [(NUM_BALLS+1)*$clog2(NUM_HOLES+1)-1:0]  ballHoleNum,
   output logic [NUM_BALLS:0]                            ballShow,
   output logic                                          drawLine,
   output logic [$clog2(NUM_HOLES+1)-1:0]                holeNumToHit,
   output logic [SCORE_W-1:0]                            score,
   output logic [$clog2(ATTEMPTS+1)-1:0]                 attemptsLeft,
   output logic                                          resetShotN,
   output logic                                          gameOver,
   output logic                                          gameWon
);

   localparam int NB = NUM_BALLS + 1;
   localparam int HW = $clog2(NUM_HOLES + 1);
   localparam int AW = $clog2(ATTEMPTS + 1);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int KW = $clog2(NUM_BALLS + 1);
   localparam int DW = SCORE_W + 3;

   typedef enum logic [2:0] {
      AIM     = 3'd0,
      ROLL    = 3'd1,
      RESOLVE = 3'd2,
      OVER    = 3'd3,
      WON     = 3'd4
   } stateT;

   stateT               state;
   stateT               stateNext;
   logic [CW-1:0]       settleCnt;
   logic                cueSunk;
   logic [NB-1:0]       sinkValid;
   logic [NB-1:0]       correctSink;
   logic [NB-1:0]       showNext;
   logic [KW-1:0]       numCorrect;
   logic                cueHit;
   logic                anyCorrect;
   logic                allStopped;
   logic                restartReq;
   logic [HW-1:0]       targetNext;
   logic [DW-1:0]       hitValue;
   logic [DW-1:0]       scoreSum;
   logic [SCORE_W-1:0]  scoreNext;
   logic                unusedCueHole;

   // Sinks only matter while balls are moving; already-hidden balls cannot sink again.
   assign sinkValid     = (state == ROLL || state == RESOLVE) ? (ballHoleHit & ballShow) : '0;
   assign showNext      = ballShow & ~sinkValid;
   assign cueHit        = sinkValid[0];
   assign allStopped    = &(ballStopped | ~ballShow);
   assign restartReq    = (state == OVER || state == WON) && enterPressed;
   assign unusedCueHole = ^ballHoleNum[HW-1:0];

   assign correctSink[0] = 1'b0;
   for (genvar i = 1; i < NB; i++) begin : g_correct
      assign correctSink[i] = sinkValid[i] &&
                              ((holeNumToHit == '0) || (ballHoleNum[i*HW +: HW] == holeNumToHit));
   end

   assign anyCorrect = |correctSink;

   always_comb begin
      numCorrect = '0;
      for (int i = 1; i < NB; i++) begin
         numCorrect = numCorrect + KW'(correctSink[i]);
      end
   end

   // Three guard bits: the MSB flags underflow, the middle bits flag overflow.
   always_comb begin
      scoreSum = {3'b000, score} + DW'(numCorrect) * hitValue;
      if (cueHit) begin
         scoreSum = scoreSum - DW'(FOUL_SCORE);
      end
      if (scoreSum[DW-1]) begin
         scoreNext = '0;
      end else if (|scoreSum[DW-2:SCORE_W]) begin
         scoreNext = '1;
      end else begin
         scoreNext = scoreSum[SCORE_W-1:0];
      end
   end

   always_comb begin
      targetNext = holeNumToHit;
      if (anyCorrect && holeNumToHit != '0) begin
         targetNext = (holeNumToHit == HW'(NUM_HOLES)) ? '0 : holeNumToHit + HW'(1);
      end
   end

`ifdef BILLIARD_STREAK_BONUS_EN
   logic [1:0] streak;
   logic       shotGood;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         streak   <= 2'd0;
         shotGood <= 1'b0;
      end else if (restartReq) begin
         streak   <= 2'd0;
         shotGood <= 1'b0;
      end else if (state == AIM && enterPressed) begin
         shotGood <= 1'b0;
      end else if (state == ROLL) begin
         if (anyCorrect) begin
            shotGood <= 1'b1;
         end
      end else if (state == RESOLVE) begin
         if ((shotGood || anyCorrect) && !(cueSunk || cueHit)) begin
            streak <= (streak == 2'd3) ? streak : streak + 2'd1;
         end else begin
            streak <= 2'd0;
         end
      end
   end

   assign hitValue = (streak != 2'd0) ? DW'(2 * HIT_SCORE) : DW'(HIT_SCORE);
`else
   assign hitValue = DW'(HIT_SCORE);
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= AIM;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         AIM: begin
            if (enterPressed) begin
               stateNext = ROLL;
            end
         end
         ROLL: begin
            if (allStopped && settleCnt == CW'(SETTLE_CYCLES - 1)) begin
               stateNext = RESOLVE;
            end
         end
         RESOLVE: begin
            if (showNext[NB-1:1] == '0) begin
               stateNext = WON;
            end else if (attemptsLeft == '0) begin
               stateNext = OVER;
            end else begin
               stateNext = AIM;
            end
         end
         OVER, WON: begin
            if (enterPressed) begin
               stateNext = AIM;
            end
         end
         default: stateNext = AIM;
      endcase
   end

   assign drawLine = (state == AIM);
   assign gameOver = (state == OVER);
   assign gameWon  = (state == WON);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         score        <= '0;
         attemptsLeft <= AW'(ATTEMPTS);
         holeNumToHit <= HW'(1);
         ballShow     <= '1;
         settleCnt    <= '0;
         cueSunk      <= 1'b0;
         resetShotN   <= 1'b1;
      end else begin
         resetShotN <= !((stateNext == RESOLVE) || restartReq);
         case (state)
            AIM: begin
               if (enterPressed) begin
                  attemptsLeft <= attemptsLeft - AW'(1);
                  settleCnt    <= '0;
                  cueSunk      <= 1'b0;
               end
            end
            ROLL, RESOLVE: begin
               ballShow     <= showNext;
               score        <= scoreNext;
               holeNumToHit <= targetNext;
               if (cueHit) begin
                  cueSunk <= 1'b1;
               end
               if (state == ROLL) begin
                  settleCnt <= (allStopped && stateNext == ROLL) ? settleCnt + CW'(1) : '0;
               end else if (stateNext == OVER) begin
                  ballShow     <= '0;
                  holeNumToHit <= '0;
               end else if (cueSunk || cueHit) begin
                  ballShow[0] <= 1'b1;
               end
            end
            OVER, WON: begin
               if (enterPressed) begin
                  score        <= '0;
                  attemptsLeft <= AW'(ATTEMPTS);
                  holeNumToHit <= HW'(1);
                  ballShow     <= '1;
                  settleCnt    <= '0;
                  cueSunk      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_billiard_match_ctrl.sv
`default_nettype none
// tb_billiard_match_ctrl : directed shot sequences with hand-computed scores, targets and flags.
// A second instance with a 5-bit score exercises the upper saturation bound.
module tb_billiard_match_ctrl;

   logic        clk = 1'b0;
   logic        resetN;
   logic        enterPressed;
   logic [3:0]  ballStopped;
   logic [3:0]  ballHoleHit;
   logic [11:0] ballHoleNum;
   logic [3:0]  ballShow;
   logic        drawLine;
   logic [2:0]  holeNumToHit;
   logic [7:0]  score;
   logic [3:0]  attemptsLeft;
   logic        resetShotN;
   logic        gameOver;
   logic        gameWon;

   logic [4:0]  satScore;
   logic [3:0]  unusedSatShow;
   logic        unusedSatLine;
   logic [2:0]  unusedSatHole;
   logic [3:0]  unusedSatAtt;
   logic        unusedSatRs;
   logic        unusedSatOver;
   logic        unusedSatWon;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   billiard_match_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .enterPressed (enterPressed),
      .ballStopped  (ballStopped),
      .ballHoleHit  (ballHoleHit),
      .ballHoleNum  (ballHoleNum),
      .ballShow     (ballShow),
      .drawLine     (drawLine),
      .holeNumToHit (holeNumToHit),
      .score        (score),
      .attemptsLeft (attemptsLeft),
      .resetShotN   (resetShotN),
      .gameOver     (gameOver),
      .gameWon      (gameWon)
   );

   billiard_match_ctrl #(.SCORE_W(5)) dutSat (
      .clk          (clk),
      .resetN       (resetN),
      .enterPressed (enterPressed),
      .ballStopped  (ballStopped),
      .ballHoleHit  (ballHoleHit),
      .ballHoleNum  (ballHoleNum),
      .ballShow     (unusedSatShow),
      .drawLine     (unusedSatLine),
      .holeNumToHit (unusedSatHole),
      .score        (satScore),
      .attemptsLeft (unusedSatAtt),
      .resetShotN   (unusedSatRs),
      .gameOver     (unusedSatOver),
      .gameWon      (unusedSatWon)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic shoot();
      ballStopped  = 4'b0000;
      enterPressed = 1'b1;
      step();
      enterPressed = 1'b0;
   endtask

   // Pocket numbers are 3 bits per ball, so each octal digit is one ball (ball0 rightmost).
   task automatic sink(input logic [3:0] mask, input logic [11:0] nums);
      ballHoleHit = mask;
      ballHoleNum = nums;
      step();
      ballHoleHit = 4'b0000;
   endtask

   task automatic settle();
      ballStopped = 4'b1111;
      repeat (4) step();
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, "_score"},  score,        0);
      check({tag, "_att"},    attemptsLeft, 10);
      check({tag, "_hole"},   holeNumToHit, 1);
      check({tag, "_show"},   ballShow,     4'b1111);
      check({tag, "_line"},   drawLine,     1);
      check({tag, "_over"},   gameOver,     0);
      check({tag, "_won"},    gameWon,      0);
   endtask

   initial begin
      resetN       = 1'b0;
      enterPressed = 1'b0;
      ballStopped  = 4'b0000;
      ballHoleHit  = 4'b0000;
      ballHoleNum  = 12'o0000;
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
      checkResetValues("reset");
      check("reset_rsn", resetShotN, 1);

      // Game 1, shot 1: cue sunk at score 0, settle interrupted once
      shoot();
      check("g1s1_att", attemptsLeft, 9);
      check("g1s1_line", drawLine, 0);
      sink(4'b0001, 12'o0000);
      check("cue_at0_score", score, 0);
      check("cue_at0_show", ballShow, 4'b1110);
      ballStopped = 4'b1111;
      repeat (3) step();
      ballStopped = 4'b0010;
      step();
      check("partial_settle_line", drawLine, 0);
      check("partial_settle_rsn", resetShotN, 1);
      settle();
      check("g1s1_resolve_rsn", resetShotN, 0);
      check("g1s1_resolve_show", ballShow, 4'b1110);
      step();
      check("g1s1_after_rsn", resetShotN, 1);
      check("cue_respawn_show", ballShow, 4'b1111);
      check("g1s1_aim_line", drawLine, 1);

      // Shot 2: wrong pocket, ignored enter, ball + cue in the same cycle
      shoot();
      check("g1s2_att", attemptsLeft, 8);
      sink(4'b0100, 12'o0400);
      check("wrong_hole_show", ballShow, 4'b1011);
      check("wrong_hole_score", score, 0);
      check("wrong_hole_target", holeNumToHit, 1);
      enterPressed = 1'b1;
      step();
      enterPressed = 1'b0;
      check("roll_enter_att", attemptsLeft, 8);
      check("roll_enter_line", drawLine, 0);
      sink(4'b0011, 12'o0010);
      check("hit_plus_foul_score", score, 8);
      check("hit_plus_foul_target", holeNumToHit, 2);
      check("hit_plus_foul_show", ballShow, 4'b1000);
      settle();
      step();
      check("g1s2_show", ballShow, 4'b1001);
      check("g1s2_score", score, 8);

      // Shot 3: last object ball correct, then cue at 24 -> 16, game won
      shoot();
      sink(4'b1000, 12'o2000);
      check("g1s3_hit_score", score, 24);
      check("g1s3_target", holeNumToHit, 3);
      sink(4'b0001, 12'o0000);
      check("cue_at24_score", score, 16);
      settle();
      step();
      check("g1_won", gameWon, 1);
      check("g1_won_line", drawLine, 0);
      check("g1_won_show", ballShow, 4'b0001);
      check("g1_won_att", attemptsLeft, 7);
      sink(4'b0001, 12'o0000);
      check("won_frozen_score", score, 16);
      enterPressed = 1'b1;
      step();
      enterPressed = 1'b0;
      checkResetValues("restart_won");
      check("restart_won_rsn", resetShotN, 0);
      step();
      check("restart_won_rsn_end", resetShotN, 1);

      // Game 2: all three in order -> 48 (saturates at 31 on the 5-bit instance)
      shoot();
      sink(4'b0010, 12'o0010);
      check("g2_b1_score", score, 16);
      settle();
      step();
      shoot();
      sink(4'b0100, 12'o0200);
      check("g2_b2_score", score, 32);
      check("sat_b2_score", satScore, 31);
      settle();
      step();
      shoot();
      sink(4'b1000, 12'o3000);
      settle();
      step();
      check("g2_won", gameWon, 1);
      check("g2_score", score, 48);
      check("g2_target", holeNumToHit, 4);
      check("g2_sat_score", satScore, 31);
      enterPressed = 1'b1;
      step();
      enterPressed = 1'b0;
      checkResetValues("restart_g2");

      // Game 3: ten empty shots -> game over
      for (int k = 1; k <= 10; k++) begin
         shoot();
         settle();
         step();
         if (k == 9) begin
            check("g3_shot9_att", attemptsLeft, 1);
            check("g3_shot9_line", drawLine, 1);
         end
      end
      check("over_flag", gameOver, 1);
      check("over_show", ballShow, 4'b0000);
      check("over_target", holeNumToHit, 0);
      check("over_line", drawLine, 0);
      check("over_att", attemptsLeft, 0);
      check("over_won", gameWon, 0);
      enterPressed = 1'b1;
      step();
      enterPressed = 1'b0;
      checkResetValues("restart_over");
      check("restart_over_rsn", resetShotN, 0);
      step();

      // Game 4: asynchronous reset in the middle of a roll
      shoot();
      sink(4'b0010, 12'o0010);
      check("g4_pre_score", score, 16);
      resetN = 1'b0;
      #2;
      checkResetValues("async_reset");
      check("async_reset_rsn", resetShotN, 1);
      step();
      resetN = 1'b1;
      step();
      check("after_reset_line", drawLine, 1);
      check("after_reset_score", score, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
`default_nettype wire
